// File: rtl/vlg_gray_decoder.sv
// rtl/vlg_gray_decoder.sv - Gray-to-binary decoder with single-bit-step checking
// Two-stage pipeline: stage 1 captures the code and step verdict, stage 2 decodes.
module vlg_gray_decoder #(
  parameter int MSB   = 7,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [MSB:0]     i_gray,
  input  logic             i_clr,
  output logic             o_vld,
  output logic [MSB:0]     o_data,
  output logic             o_step_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [MSB:0]     ONE     = {{MSB{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_v1;
  logic [MSB:0]     r_g1;
  logic             r_e1;
  logic [MSB:0]     r_last_gray;
  logic             r_have_prev;
  logic             r_vld;
  logic [MSB:0]     r_data;
  logic             r_step_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic [MSB:0]     w_diff;
  logic             w_one_hot;
  logic             w_e1;
  logic [MSB:0]     w_bin;

  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
  assign w_diff    = i_gray ^ r_last_gray;
  assign w_one_hot = (w_diff != '0) && ((w_diff & (w_diff - ONE)) == '0);
  assign w_e1      = r_have_prev && !i_clr && !w_one_hot;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i <= MSB; i++) begin
      w_bin[i] = ^(r_g1 >> i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1        <= 1'b0;
      r_g1        <= '0;
      r_e1        <= 1'b0;
      r_last_gray <= '0;
      r_have_prev <= 1'b0;
    end else begin
      r_v1 <= i_en;
      if (i_en) begin
        r_g1        <= i_gray;
        r_e1        <= w_e1;
        r_last_gray <= i_gray;
        r_have_prev <= 1'b1;
      end else if (i_clr) begin
        r_have_prev <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld      <= 1'b0;
      r_data     <= '0;
      r_step_err <= 1'b0;
    end else begin
      r_vld <= r_v1;
      if (r_v1) begin
        r_data     <= w_bin;
        r_step_err <= r_e1;
      end else begin
        r_step_err <= 1'b0;
      end
    end
  end

  // Clear takes priority over an error being counted on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (i_clr) begin
      r_err_cnt <= '0;
    end else if (r_vld && r_step_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

  assign o_vld      = r_vld;
  assign o_data     = r_data;
  assign o_step_err = r_step_err;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_vlg_gray_decoder.sv
// tb/tb_vlg_gray_decoder.sv - self-checking bench for vlg_gray_decoder
// Two instances (8-bit and 2-bit error counters) share one stimulus stream.
module tb_vlg_gray_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] gray;
  logic       clr;

  logic       a_vld, b_vld;
  logic [7:0] a_data, b_data;
  logic       a_err, b_err;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vlg_gray_decoder #(.MSB(7), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_gray(gray), .i_clr(clr),
    .o_vld(a_vld), .o_data(a_data), .o_step_err(a_err), .o_err_cnt(a_cnt)
  );

  vlg_gray_decoder #(.MSB(7), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_gray(gray), .i_clr(clr),
    .o_vld(b_vld), .o_data(b_data), .o_step_err(b_err), .o_err_cnt(b_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: decode via inverse table of the encoder, distance via popcount.
  int  inv_tbl [256];
  bit  m_have_prev;
  int  m_last;
  bit  m_pend_v;
  int  m_pend_d;
  bit  m_pend_e;
  bit  x_vld;
  int  x_data;
  bit  x_err;
  int  x_cnt8;
  int  x_cnt2;

  initial begin
    for (int i = 0; i < 256; i++) inv_tbl[i ^ (i >> 1)] = i;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have_prev = 0; m_last = 0; m_pend_v = 0; m_pend_d = 0; m_pend_e = 0;
      x_vld = 0; x_data = 0; x_err = 0; x_cnt8 = 0; x_cnt2 = 0;
    end else begin
      if (clr) begin
        x_cnt8 = 0; x_cnt2 = 0;
      end else if (x_vld && x_err) begin
        x_cnt8 = (x_cnt8 < 255) ? x_cnt8 + 1 : 255;
        x_cnt2 = (x_cnt2 < 3) ? x_cnt2 + 1 : 3;
      end
      x_vld = m_pend_v;
      if (m_pend_v) begin
        x_data = m_pend_d; x_err = m_pend_e;
      end else begin
        x_err = 0;
      end
      m_pend_v = en;
      if (en) begin
        m_pend_d    = inv_tbl[gray];
        m_pend_e    = m_have_prev && !clr && ($countones(gray ^ m_last[7:0]) != 1);
        m_last      = int'(gray);
        m_have_prev = 1;
      end else if (clr) begin
        m_have_prev = 0;
      end
    end
  end

  int got_d [$];
  int got_e [$];

  always @(posedge clk) begin
    #2;
    check("vld_a",  a_vld,  x_vld);
    check("vld_b",  b_vld,  x_vld);
    check("data_a", a_data, x_data);
    check("data_b", b_data, x_data);
    check("err_a",  a_err,  x_err);
    check("err_b",  b_err,  x_err);
    check("cnt_a",  a_cnt,  x_cnt8);
    check("cnt_b",  b_cnt,  x_cnt2);
    if (a_vld) begin
      got_d.push_back(a_data);
      got_e.push_back(a_err);
    end
  end

  task automatic drive(input bit e, input logic [7:0] g, input bit c);
    @(negedge clk);
    en = e; gray = g; clr = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, gray, 0);
  endtask

  task automatic flush();
    idle(3);
  endtask

  task automatic start_test();
    drive(0, 8'h00, 1);
    flush();
    got_d.delete();
    got_e.delete();
  endtask

  task automatic check_seq(input string name, input int d [$], input int e [$]);
    check({name, "_len"}, got_d.size(), d.size());
    for (int i = 0; i < d.size() && i < got_d.size(); i++) begin
      check({name, "_d"}, got_d[i], d[i]);
      check({name, "_e"}, got_e[i], e[i]);
    end
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; en = 1'b0; gray = 8'h00; clr = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("rst_vld",  a_vld, 0);
    check("rst_data", a_data, 0);
    check("rst_err",  a_err, 0);
    check("rst_cnt",  a_cnt, 0);
    rst_n = 1'b1;

    // 1: full 256-code up-count burst
    got_d.delete(); got_e.delete();
    for (int i = 0; i < 256; i++) drive(1, 8'(i ^ (i >> 1)), 0);
    idle(4);
    check("t1_len", got_d.size(), 256);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++) if (got_d[i] != i || got_e[i] != 0) bad++;
    check("t1_seq_bad", bad, 0);
    check("t1_cnt", a_cnt, 0);

    // 2: wrap in both directions, clear between the pairs
    start_test();
    drive(1, 8'h80, 0); drive(1, 8'h00, 0);
    drive(1, 8'h00, 1); drive(1, 8'h80, 0);
    flush();
    check_seq("t2", '{255, 0, 0, 255}, '{0, 0, 0, 0});
    check("t2_cnt", a_cnt, 0);

    // 3: distance-2 step then a repeat
    start_test();
    drive(1, 8'h07, 0); drive(1, 8'h04, 0); drive(1, 8'h04, 0);
    flush();
    check_seq("t3", '{5, 7, 7}, '{0, 1, 1});
    check("t3_cnt_a", a_cnt, 2);
    check("t3_cnt_b", b_cnt, 2);

    // 4: idle gaps keep history
    start_test();
    drive(1, 8'h0F, 0); idle(3);
    drive(1, 8'h0E, 0); idle(3);
    drive(1, 8'h0A, 0);
    flush();
    check_seq("t4", '{10, 11, 12}, '{0, 0, 0});

    // 5: saturation of the 2-bit counter, then clear with a word
    start_test();
    for (int i = 0; i < 5; i++) drive(1, 8'h05, 0);
    flush();
    check("t5_cnt_b_sat", b_cnt, 3);
    check("t5_cnt_a", a_cnt, 4);
    got_d.delete(); got_e.delete();
    drive(1, 8'h05, 1);
    flush();
    check_seq("t5", '{6}, '{0});
    check("t5_cnt_b_clr", b_cnt, 0);
    check("t5_cnt_a_clr", a_cnt, 0);

    // 6: reset with two words in flight
    start_test();
    drive(1, 8'h01, 0); drive(1, 8'h03, 0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_vld_drop", a_vld, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_d.delete(); got_e.delete();
    idle(3);
    check("t6_no_stale", got_d.size(), 0);
    drive(1, 8'hC0, 0);
    flush();
    check_seq("t6", '{128}, '{0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
